// File: rtl/keypad_entry_if.sv
// Keypad entry bus: raw keys and entry controls in, debounced key and BCD entry out.
// master drives the keypad side; slave is the keypad_entry block.
interface keypad_entry_if #(
  parameter int unsigned NUM_DIGITS = 6
) ();

  logic [9:0]              keypad;
  logic                    load_en;
  logic                    clr;
  logic                    key_valid;
  logic [3:0]              key_code;
  logic [4*NUM_DIGITS-1:0] entry_bcd;
  logic [3:0]              digit_cnt;
  logic                    entry_done;

  modport master (
    output keypad,
    output load_en,
    output clr,
    input  key_valid,
    input  key_code,
    input  entry_bcd,
    input  digit_cnt,
    input  entry_done
  );

  modport slave (
    input  keypad,
    input  load_en,
    input  clr,
    output key_valid,
    output key_code,
    output entry_bcd,
    output digit_cnt,
    output entry_done
  );

endinterface

// File: rtl/keypad_entry.sv
// Keypad entry: debounces a one-hot 10-key keypad, emits one key_valid pulse per
// accepted press and shifts accepted digits into a NUM_DIGITS-digit BCD entry.
// Optional feature: define KEYPAD_AUTOREPEAT_EN to build the hold counter that
// re-issues key_valid while a key stays held.
module keypad_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned NUM_DIGITS      = 6,
  parameter int unsigned REPEAT_DELAY    = 500,
  parameter int unsigned REPEAT_PERIOD   = 200
) (
  input logic           clk,
  input logic           rst,
  keypad_entry_if.slave bus
);

  localparam int unsigned EntryW = 4 * NUM_DIGITS;
  localparam int unsigned CntW   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StDebounce, StPressed, StRelease} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_inc;
  logic [9:0]        pat_q;
  logic [3:0]        pat_idx;
  logic              key_one_hot;
  logic              key_valid_q;
  logic [3:0]        key_code_q;
  logic [EntryW-1:0] entry_q;
  logic [3:0]        digit_cnt_q;
  logic [3:0]        digit_cnt_inc;
  logic              entry_done_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);

  logic [HoldW-1:0] hold_q;
  logic [HoldW-1:0] hold_inc;
  logic [HoldW-1:0] hold_lim;
  logic             rep_q;

  assign hold_inc = hold_q + 1'b1;
  // First repeat waits the long delay; later repeats use the period.
  assign hold_lim = rep_q ? HoldW'(REPEAT_PERIOD) : HoldW'(REPEAT_DELAY);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  assign key_one_hot   = ($countones(bus.keypad) == 1);
  assign cnt_inc       = cnt_q + 1'b1;
  assign digit_cnt_inc = digit_cnt_q + 4'd1;

  // Encode the latched one-hot pattern into its digit index.
  always_comb begin
    pat_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (pat_q[i]) pat_idx = 4'(i);
    end
  end

  // Debounce FSM with registered key_valid/key_code.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      pat_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
`ifdef KEYPAD_AUTOREPEAT_EN
      hold_q      <= '0;
      rep_q       <= 1'b0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (key_one_hot) begin
            state_q <= StDebounce;
            pat_q   <= bus.keypad;
            cnt_q   <= CntW'(1);
          end
        end
        StDebounce: begin
          if (bus.keypad == pat_q) begin
            if (cnt_inc == CntW'(DEBOUNCE_CYCLES)) begin
              state_q     <= StPressed;
              key_valid_q <= 1'b1;
              key_code_q  <= pat_idx;
`ifdef KEYPAD_AUTOREPEAT_EN
              hold_q      <= '0;
              rep_q       <= 1'b0;
`endif
            end else begin
              cnt_q <= cnt_inc;
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StPressed: begin
          // The first zero sample already counts towards the release debounce.
          if (bus.keypad == 10'd0) begin
            state_q <= StRelease;
            cnt_q   <= CntW'(1);
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          if (bus.keypad == pat_q) begin
            if (hold_inc == hold_lim) begin
              key_valid_q <= 1'b1;
              key_code_q  <= pat_idx;
              hold_q      <= '0;
              rep_q       <= 1'b1;
            end else begin
              hold_q <= hold_inc;
            end
          end else begin
            hold_q <= '0;
            rep_q  <= 1'b0;
          end
`endif
        end
        StRelease: begin
          if (bus.keypad == 10'd0) begin
            if (cnt_inc == CntW'(DEBOUNCE_CYCLES)) begin
              state_q <= StIdle;
            end else begin
              cnt_q <= cnt_inc;
            end
          end else begin
            // Release bounce: back to held, no new pulse.
            state_q <= StPressed;
`ifdef KEYPAD_AUTOREPEAT_EN
            hold_q  <= '0;
            rep_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Entry register: updated on the edge after key_valid; clr always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q      <= '0;
      digit_cnt_q  <= 4'd0;
      entry_done_q <= 1'b0;
    end else begin
      entry_done_q <= 1'b0;
      if (bus.clr) begin
        entry_q     <= '0;
        digit_cnt_q <= 4'd0;
      end else if (key_valid_q && bus.load_en && (digit_cnt_q < 4'(NUM_DIGITS))) begin
        // Truncating cast drops the oldest digit position (empty while not full).
        entry_q     <= EntryW'({entry_q, key_code_q});
        digit_cnt_q <= digit_cnt_inc;
        if (digit_cnt_inc == 4'(NUM_DIGITS)) entry_done_q <= 1'b1;
      end
    end
  end

  assign bus.key_valid  = key_valid_q;
  assign bus.key_code   = key_code_q;
  assign bus.entry_bcd  = entry_q;
  assign bus.digit_cnt  = digit_cnt_q;
  assign bus.entry_done = entry_done_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry (DEBOUNCE_CYCLES=4, NUM_DIGITS=6). Expected pulses and
// entry contents are pushed to a scoreboard as keys are driven and checked by a
// negedge monitor. Define KEYPAD_AUTOREPEAT_EN to also exercise auto-repeat.
module tb_keypad_entry;

  localparam int unsigned Deb = 4;

  typedef struct {
    logic [3:0]  code;
    int          cyc;
    logic [23:0] entry;
    logic [3:0]  cnt;
    logic        done;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  exp_t        sb[$];
  logic [23:0] m_entry;
  logic [3:0]  m_cnt;

  keypad_entry_if #(.NUM_DIGITS(6)) bus ();

  keypad_entry #(
    .DEBOUNCE_CYCLES(Deb),
    .NUM_DIGITS     (6),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model the entry update for one expected pulse and queue it.
  task automatic push_key(input logic [3:0] code, input bit clr_hit, input int at_cyc);
    exp_t e;
    e.code = code;
    e.cyc  = at_cyc;
    e.done = 1'b0;
    if (clr_hit) begin
      m_entry = '0;
      m_cnt   = 4'd0;
    end else if (bus.load_en && m_cnt < 4'd6) begin
      m_entry = {m_entry[19:0], code};
      m_cnt   = m_cnt + 4'd1;
      e.done  = (m_cnt == 4'd6);
    end
    e.entry = m_entry;
    e.cnt   = m_cnt;
    sb.push_back(e);
  endtask

  task automatic press(input logic [9:0] pat, input logic [3:0] code, input int hold,
                       input bit expect_pulse);
    bus.keypad = pat;
    if (expect_pulse) push_key(code, 1'b0, cyc + Deb);
    tick(hold);
    bus.keypad = '0;
    tick(6);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_key_valid"}, 32'(bus.key_valid), 0);
    check_eq({tag, "_key_code"}, 32'(bus.key_code), 0);
    check_eq({tag, "_entry_bcd"}, 32'(bus.entry_bcd), 0);
    check_eq({tag, "_digit_cnt"}, 32'(bus.digit_cnt), 0);
    check_eq({tag, "_entry_done"}, 32'(bus.entry_done), 0);
  endtask

  // Monitor: pulses pop the scoreboard; the entry is checked one edge later.
  initial begin
    exp_t e;
    bit   upd_pending;
    upd_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (upd_pending) begin
          check_eq("entry_bcd", 32'(bus.entry_bcd), 32'(e.entry));
          check_eq("digit_cnt", 32'(bus.digit_cnt), 32'(e.cnt));
          check_eq("entry_done", 32'(bus.entry_done), 32'(e.done));
          upd_pending = 1'b0;
        end else if (bus.entry_done) begin
          check_eq("spurious_entry_done", 1, 0);
        end
        if (bus.key_valid) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_key_valid", 1, 0);
          end else begin
            e = sb.pop_front();
            check_eq("key_code", 32'(bus.key_code), 32'(e.code));
            check_eq("pulse_cycle", 32'(cyc), 32'(e.cyc));
            upd_pending = 1'b1;
          end
        end
      end else begin
        upd_pending = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int digs[6];
    digs = '{1, 2, 3, 0, 4, 5};
    cyc        = 0;
    n_checks   = 0;
    n_fail     = 0;
    m_entry    = '0;
    m_cnt      = 4'd0;
    rst        = 1'b1;
    bus.keypad = '0;
    bus.load_en = 1'b0;
    bus.clr    = 1'b0;
    tick(3);
    check_outputs_zero("reset");
    rst = 1'b0;
    tick(2);

    // Clean press of key 3, held 10 cycles.
    press(10'h008, 4'd3, 10, 1'b1);
    check_eq("code_hold", 32'(bus.key_code), 3);
    check_eq("valid_low", 32'(bus.key_valid), 0);

    // Bounce: 2 samples, a dropout, then a stable hold of 6.
    bus.keypad = 10'h020;
    tick(2);
    bus.keypad = '0;
    tick(1);
    bus.keypad = 10'h020;
    push_key(4'd5, 1'b0, cyc + Deb);
    tick(6);
    bus.keypad = '0;
    tick(6);

    // Two keys at once never count as a press.
    press(10'h003, 4'd0, 10, 1'b0);

    // Release bounce after 3 zeros: no new pulse. Exactly 4 zeros re-arms IDLE.
    bus.keypad = 10'h002;
    push_key(4'd1, 1'b0, cyc + Deb);
    tick(6);
    bus.keypad = '0;
    tick(3);
    bus.keypad = 10'h002;
    tick(3);
    bus.keypad = '0;
    tick(4);
    press(10'h002, 4'd1, 6, 1'b1);

    // Full entry 1,2,3,0,4,5 then a 7th key that must not shift in.
    bus.load_en = 1'b1;
    foreach (digs[i]) press(10'(1 << digs[i]), 4'(digs[i]), 6, 1'b1);
    check_eq("full_entry", 32'(bus.entry_bcd), 32'h123045);
    check_eq("full_cnt", 32'(bus.digit_cnt), 6);
    press(10'h200, 4'd9, 6, 1'b1);
    check_eq("full_hold_entry", 32'(bus.entry_bcd), 32'h123045);

    // clr on the same edge as key 7's entry update.
    bus.keypad = 10'h080;
    push_key(4'd7, 1'b1, cyc + Deb);
    tick(Deb);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    tick(2);
    bus.keypad = '0;
    tick(6);

    // load_en low: key reported, entry frozen.
    bus.load_en = 1'b0;
    press(10'h100, 4'd8, 6, 1'b1);
    check_eq("frozen_code", 32'(bus.key_code), 8);

    // clr with no key pending.
    bus.load_en = 1'b1;
    press(10'h040, 4'd6, 6, 1'b1);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    m_entry = '0;
    m_cnt   = 4'd0;
    check_eq("clr_alone_entry", 32'(bus.entry_bcd), 0);
    check_eq("clr_alone_cnt", 32'(bus.digit_cnt), 0);

    // Reset while debouncing a held key, then a fresh full debounce.
    press(10'h040, 4'd6, 6, 1'b1);
    bus.keypad = 10'h200;
    tick(2);
    rst = 1'b1;
    tick(1);
    check_outputs_zero("rst_mid");
    m_entry = '0;
    m_cnt   = 4'd0;
    rst = 1'b0;
    push_key(4'd9, 1'b0, cyc + Deb);
    tick(6);
    bus.keypad = '0;
    tick(6);

`ifdef KEYPAD_AUTOREPEAT_EN
    begin
      int acc;
      int reps[5];
      reps = '{10, 15, 20, 25, 30};
      bus.load_en = 1'b0;
      bus.keypad  = 10'h004;
      acc = cyc + Deb;
      push_key(4'd2, 1'b0, acc);
      foreach (reps[i]) push_key(4'd2, 1'b0, acc + reps[i]);
      tick(Deb + 30);
      bus.keypad = '0;
      tick(6);
    end
`endif

    tick(5);
    check_eq("scoreboard_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
